victim_cache: RTL
=================

// Module: victim_cache
// PURPOSE
//  Small fully-associative victim cache downstream of the GT_direct_map L1.
//  Captures 256-bit lines evicted by the L1 (its toMemData path) and serves L1 misses.
//  A hit returns the full line plus the addressed byte, and the entry is removed
//  (swap semantics: the line moves back into the L1).
// PARAMETERS
//  ENTRIES   4    number of line entries, >=2
//  ADDR_W    32   byte address width
//  LINE_W    256  line width in bits (32 bytes)
//  OFFSET_W  5    byte-offset bits; tag = addr[ADDR_W-1:OFFSET_W]
// PORTS
//  CLK          in   1        clock, all state on rising edge
//  RST          in   1        synchronous, active-high reset
//  evictValid   in   1        insert request this cycle
//  evictAddr    in   ADDR_W   address of evicted line (offset bits ignored)
//  evictData    in   LINE_W   evicted line data
//  lookupValid  in   1        lookup request this cycle (L1 miss)
//  lookupAddr   in   ADDR_W   byte address being looked up
//  vcValid      out  1        registered: lookup result valid
//  vcHit        out  1        registered: lookup hit
//  vcData       out  LINE_W   registered: hit line, 0 on miss
//  vcByte       out  8        registered: byte lookupAddr[4:0] of the hit line, 0 on miss
//  occupancy    out  clog2(ENTRIES+1)  number of valid entries
// BEHAVIOUR
//  - Reset: all entries invalid, replPtr=0; vcValid=vcHit=0, vcData=0, vcByte=0,
//    occupancy=0. RST overrides any request in the same cycle.
//    Reset mid-lookup discards the result.
//  - Per entry state: valid bit, tag, line data.
//  - Lookup latency 1 cycle: request at edge N, result at outputs after edge N+1.
//    vcValid pulses once per request; outputs hold until the next request.
//  - Lookup compares against state before this cycle's insert.
//    A tag match on a valid entry gives vcHit=1 and latches the data.
//    On a hit the entry is invalidated unless the same cycle's insert targets it.
//  - Byte select is little-endian: byte i = data[8i+7:8i], i = lookupAddr[OFFSET_W-1:0].
//  - Insert target, first rule that applies:
//    (a) a valid entry with matching tag: overwrite data in place (no duplicates);
//    (b) the slot freed by a same-cycle lookup hit;
//    (c) the lowest-index invalid entry;
//    (d) entry replPtr (FIFO victim); then replPtr <= (replPtr+1) mod ENTRIES.
//    Only rule (d) advances replPtr.
//  - Same-tag evict and lookup in one cycle: lookup returns the OLD data.
//    The entry stays valid with the NEW data.
//  - occupancy updates 1 cycle after the request; it never exceeds ENTRIES
//    and never underflows.
//  - Evicted lines dropped by rule (d) are clean: no writeback port.
// TESTING
//  1 Reset, then lookup 0x00100001
//    -> vcValid=1, vcHit=0, vcData=0, vcByte=0, occupancy=0.
//  2 Insert addr 0x00100000 with data FFFF_EEEE_..._1111_0000; lookup 0x00100002 next cycle
//    -> vcHit=1, vcByte=0x11, full line returned.
//    Occupancy goes 0 -> 1 -> 0 (entry removed after the hit).
//  3 Insert 0x00100000, 0x00200000, 0x00300000, 0x00400000, then 0x00500000
//    -> occupancy saturates at 4.
//    Lookup 0x00100000 misses; lookups of 0x00200000 and 0x00500000 hit.
//  4 Insert 0x00300000 (data A), then 0x00300003 (data B)
//    -> occupancy=1; lookup returns B.
//  5 Same cycle: lookup 0x00200000 (hit) and insert 0x00600000 with the cache full
//    -> hit returns the old line; 0x00600000 takes the freed slot.
//    replPtr unchanged; occupancy stays 4.
//  6 Assert RST in the cycle after a lookup request and with 3 entries valid
//    -> vcValid=0 and occupancy=0 next cycle; a subsequent lookup of a prior tag misses.

Source files
------------

// File: rtl/victim_cache.sv
// Fully-associative victim cache holding lines evicted from the direct-mapped L1.
// A lookup hit hands the line back and frees the entry (swap semantics).
module victim_cache #(
  parameter int ENTRIES  = 4,
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             evictValid,
  input  logic [ADDR_W-1:0]                evictAddr,
  input  logic [LINE_W-1:0]                evictData,
  input  logic                             lookupValid,
  input  logic [ADDR_W-1:0]                lookupAddr,
  output logic                             vcValid,
  output logic                             vcHit,
  output logic [LINE_W-1:0]                vcData,
  output logic [7:0]                       vcByte,
  output logic [$clog2(ENTRIES+1)-1:0]     occupancy
);
  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0]             r_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  r_tag;
  logic [ENTRIES-1:0][LINE_W-1:0] r_data;
  logic [IDX_W-1:0]               r_repl_ptr;

  logic [TAG_W-1:0]   w_lk_tag, w_ev_tag;
  logic               w_lk_hit, w_lk_take, w_ev_match, w_free, w_adv;
  logic [IDX_W-1:0]   w_lk_idx, w_ev_idx, w_free_idx, w_ins_idx;
  logic [ENTRIES-1:0] w_valid_nxt;
  logic [OCC_W-1:0]   w_occ_nxt;
  logic [LINE_W-1:0]  w_lk_data;
  logic [7:0]         w_lk_byte;

  assign w_lk_tag = lookupAddr[ADDR_W-1:OFFSET_W];
  assign w_ev_tag = evictAddr[ADDR_W-1:OFFSET_W];

  // Tag searches run against the state before this cycle's insert.
  always_comb begin
    w_lk_hit   = 1'b0;
    w_lk_idx   = '0;
    w_ev_match = 1'b0;
    w_ev_idx   = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && r_tag[i] == w_lk_tag) begin
        w_lk_hit = 1'b1;
        w_lk_idx = IDX_W'(i);
      end
      if (r_valid[i] && r_tag[i] == w_ev_tag) begin
        w_ev_match = 1'b1;
        w_ev_idx   = IDX_W'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_lk_take = lookupValid & w_lk_hit;
  assign w_lk_data = r_data[w_lk_idx];
  assign w_lk_byte = w_lk_data[{lookupAddr[OFFSET_W-1:0], 3'b000} +: 8];

  always_comb begin
    w_adv = 1'b0;
    if (w_ev_match)     w_ins_idx = w_ev_idx;
    else if (w_lk_take) w_ins_idx = w_lk_idx;
    else if (w_free)    w_ins_idx = w_free_idx;
    else begin
      w_ins_idx = r_repl_ptr;
      w_adv     = evictValid;
    end
  end

  // Insert wins over hit-invalidate so a same-tag swap keeps the new line.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_lk_take)  w_valid_nxt[w_lk_idx]  = 1'b0;
    if (evictValid) w_valid_nxt[w_ins_idx] = 1'b1;
    w_occ_nxt = '0;
    for (int i = 0; i < ENTRIES; i++)
      w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid    <= '0;
      r_repl_ptr <= '0;
      vcValid    <= 1'b0;
      vcHit      <= 1'b0;
      vcData     <= '0;
      vcByte     <= '0;
      occupancy  <= '0;
    end else begin
      r_valid   <= w_valid_nxt;
      occupancy <= w_occ_nxt;
      if (w_adv) begin
        if (r_repl_ptr == IDX_W'(ENTRIES - 1)) r_repl_ptr <= '0;
        else                                   r_repl_ptr <= r_repl_ptr + IDX_W'(1);
      end
      vcValid <= lookupValid;
      if (lookupValid) begin
        vcHit  <= w_lk_hit;
        vcData <= w_lk_hit ? w_lk_data : '0;
        vcByte <= w_lk_hit ? w_lk_byte : '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && evictValid) begin
      r_tag[w_ins_idx]  <= w_ev_tag;
      r_data[w_ins_idx] <= evictData;
    end
  end
endmodule
